// File: rtl/bc_pkg.sv
// Shared definitions for the basic-computer execution slice: default widths and ALU op codes.
// OP_SUB is only decoded when ALU_SUB_EN is defined.
package bc_pkg;
   localparam int BC_WIDTH  = 16;
   localparam int BC_ADDR_W = 12;

   localparam logic [3:0] OP_PASS_AC = 4'd0;
   localparam logic [3:0] OP_AND     = 4'd1;
   localparam logic [3:0] OP_ADD     = 4'd2;
   localparam logic [3:0] OP_PASS_DR = 4'd3;
   localparam logic [3:0] OP_CMA     = 4'd4;
   localparam logic [3:0] OP_CIR     = 4'd5;
   localparam logic [3:0] OP_CIL     = 4'd6;
   localparam logic [3:0] OP_INC     = 4'd7;
   localparam logic [3:0] OP_CLR     = 4'd8;
   localparam logic [3:0] OP_SUB     = 4'd9;
endpackage

// File: rtl/bc_alu_core.sv
// Combinational ALU (AC op DR) with carry/shift-out, zero, negative and signed-overflow flags.
// Optional feature macro: ALU_SUB_EN enables OPSEL 9 as SUB; otherwise it falls back to PASS_AC.
module bc_alu_core
   import bc_pkg::*;
#(
   parameter int WIDTH = BC_WIDTH
) (
   input  logic [WIDTH-1:0] ac,
   input  logic [WIDTH-1:0] dr,
   input  logic             e_in,
   input  logic [3:0]       opsel,
   output logic [WIDTH-1:0] result,
   output logic             co,
   output logic             z,
   output logic             n,
   output logic             ovf
);

   logic [WIDTH:0] sum;

   always_comb begin
      result = ac;
      co     = 1'b0;
      ovf    = 1'b0;
      sum    = '0;
      case (opsel)
         OP_PASS_AC: result = ac;
         OP_AND:     result = ac & dr;
         OP_ADD: begin
            sum    = {1'b0, ac} + {1'b0, dr};
            result = sum[WIDTH-1:0];
            co     = sum[WIDTH];
            ovf    = (ac[WIDTH-1] == dr[WIDTH-1]) && (result[WIDTH-1] != ac[WIDTH-1]);
         end
         OP_PASS_DR: result = dr;
         OP_CMA:     result = ~ac;
         OP_CIR: begin
            result = {e_in, ac[WIDTH-1:1]};
            co     = ac[0];
         end
         OP_CIL: begin
            result = {ac[WIDTH-2:0], e_in};
            co     = ac[WIDTH-1];
         end
         OP_INC: begin
            sum    = {1'b0, ac} + {{WIDTH{1'b0}}, 1'b1};
            result = sum[WIDTH-1:0];
            co     = sum[WIDTH];
            ovf    = (ac == {1'b0, {(WIDTH-1){1'b1}}});
         end
         OP_CLR:     result = '0;
`ifdef ALU_SUB_EN
         // Two's-complement subtract; carry out of 1 means no borrow.
         OP_SUB: begin
            sum    = {1'b0, ac} + {1'b0, ~dr} + {{WIDTH{1'b0}}, 1'b1};
            result = sum[WIDTH-1:0];
            co     = sum[WIDTH];
            ovf    = (ac[WIDTH-1] != dr[WIDTH-1]) && (result[WIDTH-1] != ac[WIDTH-1]);
         end
`endif
         default:    result = ac;
      endcase
   end

   assign z = (result == '0);
   assign n = result[WIDTH-1];

endmodule

// File: rtl/bc_exec_unit.sv
// Execution/storage slice: ALU core, E extend flip-flop and 2**ADDR_W x WIDTH main memory.
// Optional feature macro ALU_SUB_EN (OPSEL 9 = SUB) is honoured inside bc_alu_core.
module bc_exec_unit
   import bc_pkg::*;
#(
   parameter int WIDTH  = BC_WIDTH,
   parameter int ADDR_W = BC_ADDR_W
) (
   input  logic              clk,
   input  logic              RST_N,
   input  logic [WIDTH-1:0]  AC,
   input  logic [WIDTH-1:0]  DR,
   input  logic [3:0]        OPSEL,
   output logic [WIDTH-1:0]  RESULT,
   output logic              CO,
   output logic              Z,
   output logic              N,
   output logic              OVF,
   input  logic              E_LOAD,
   input  logic              E_CMP,
   input  logic              E_CLR,
   output logic              E,
   input  logic              MEM_WE,
   input  logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [WIDTH-1:0]  MEM_WDATA,
   output logic [WIDTH-1:0]  MEM_RDATA
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic             e_q;
   logic [WIDTH-1:0] mem [DEPTH];

   bc_alu_core #(.WIDTH(WIDTH)) u_alu (
      .ac     (AC),
      .dr     (DR),
      .e_in   (e_q),
      .opsel  (OPSEL),
      .result (RESULT),
      .co     (CO),
      .z      (Z),
      .n      (N),
      .ovf    (OVF)
   );

   // Clear beats load beats complement when several controls coincide.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N)      e_q <= 1'b0;
      else if (E_CLR)  e_q <= 1'b0;
      else if (E_LOAD) e_q <= CO;
      else if (E_CMP)  e_q <= ~e_q;
   end

   assign E = e_q;

   // Memory is deliberately outside reset; reads are asynchronous so a write shows after the edge.
   always_ff @(posedge clk) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
   end

   assign MEM_RDATA = mem[MEM_ADDR];

endmodule

// File: tb/tb_bc_exec_unit.sv
// Directed bench for bc_exec_unit: driver pushes hand-computed expectations, negedge monitor compares.
module tb_bc_exec_unit;
  import bc_pkg::*;

  logic        clk;
  logic        RST_N;
  logic [15:0] AC;
  logic [15:0] DR;
  logic [3:0]  OPSEL;
  logic [15:0] RESULT;
  logic        CO;
  logic        Z;
  logic        N;
  logic        OVF;
  logic        E_LOAD;
  logic        E_CMP;
  logic        E_CLR;
  logic        E;
  logic        MEM_WE;
  logic [11:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [15:0] MEM_RDATA;

  // Packed observation: {RESULT, CO, Z, N, OVF, E, MEM_RDATA}
  localparam int W = 37;
  localparam logic [W-1:0] M_ALL  = {W{1'b1}};
  localparam logic [W-1:0] M_NORD = {{21{1'b1}}, 16'h0000};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  bc_exec_unit dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .AC        (AC),
    .DR        (DR),
    .OPSEL     (OPSEL),
    .RESULT    (RESULT),
    .CO        (CO),
    .Z         (Z),
    .N         (N),
    .OVF       (OVF),
    .E_LOAD    (E_LOAD),
    .E_CMP     (E_CMP),
    .E_CLR     (E_CLR),
    .E         (E),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d required completion", checks);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive(input logic [15:0] ac, input logic [15:0] dr, input logic [3:0] op,
                       input logic eload, input logic ecmp, input logic eclr,
                       input logic we, input logic [11:0] addr, input logic [15:0] wd);
    @(posedge clk);
    #1;
    AC = ac; DR = dr; OPSEL = op;
    E_LOAD = eload; E_CMP = ecmp; E_CLR = eclr;
    MEM_WE = we; MEM_ADDR = addr; MEM_WDATA = wd;
  endtask

  task automatic expect_out(input string name, input logic [15:0] res, input logic co,
                            input logic ovf, input logic e, input logic [15:0] rd,
                            input logic chk_rd);
    exp_q.push_back({res, co, (res == 16'h0000), res[15], ovf, e, rd});
    mask_q.push_back(chk_rd ? M_ALL : M_NORD);
    name_q.push_back(name);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v, msk;
    string        nm;
    act = {RESULT, CO, Z, N, OVF, E, MEM_RDATA};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      msk   = mask_q.pop_front();
      nm    = name_q.pop_front();
      checks++;
      if ((act & msk) !== (exp_v & msk)) begin
        errors++;
        $display("FAIL %s: got res=%h co=%b z=%b n=%b ovf=%b e=%b rd=%h, expected res=%h co=%b z=%b n=%b ovf=%b e=%b rd=%h",
                 nm, act[36:21], act[20], act[19], act[18], act[17], act[16], act[15:0],
                 exp_v[36:21], exp_v[20], exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
      end
    end
    if (done) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      if ((errors == 0) && (checks >= 12))
        $display("PASS tb_bc_exec_unit");
      else
        $display("FAIL tb_bc_exec_unit: errors=%0d checks=%0d", errors, checks);
      $finish;
    end
  end

  // stimulus
  initial begin
    RST_N = 1'b0;
    AC = '0; DR = '0; OPSEL = OP_PASS_AC;
    E_LOAD = 1'b0; E_CMP = 1'b0; E_CLR = 1'b0;
    MEM_WE = 1'b0; MEM_ADDR = '0; MEM_WDATA = '0;
    repeat (2) @(posedge clk);
    #1 RST_N = 1'b1;

    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 0, 0, 12'h000, 16'h0);
    expect_out("reset_e", 16'h0000, 0, 0, 0, 16'h0, 0);
    drive(16'hFFFF, 16'h0001, OP_ADD, 1, 0, 0, 0, 12'h000, 16'h0);
    expect_out("add_wrap", 16'h0000, 1, 0, 0, 16'h0, 0);
    drive(16'h1234, 16'h0000, OP_PASS_AC, 0, 0, 0, 0, 12'h000, 16'h0);
    expect_out("e_load_co", 16'h1234, 0, 0, 1, 16'h0, 0);
    drive(16'h7FFF, 16'h0001, OP_ADD, 0, 0, 0, 0, 12'h000, 16'h0);
    expect_out("add_ovf", 16'h8000, 0, 1, 1, 16'h0, 0);
    drive(16'h0003, 16'h0000, OP_CIR, 0, 0, 0, 0, 12'h000, 16'h0);
    expect_out("cir", 16'h8001, 1, 0, 1, 16'h0, 0);
    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 1, 0, 12'h000, 16'h0);
    expect_out("e_clr_req", 16'h0000, 0, 0, 1, 16'h0, 0);
    drive(16'h8000, 16'h0000, OP_CIL, 0, 0, 0, 0, 12'h000, 16'h0);
    expect_out("cil", 16'h0000, 1, 0, 0, 16'h0, 0);
    drive(16'h0F0F, 16'h0000, OP_CMA, 0, 1, 0, 0, 12'h000, 16'h0);
    expect_out("cma", 16'hF0F0, 0, 0, 0, 16'h0, 0);
    drive(16'hFF00, 16'h0F0F, OP_AND, 0, 0, 0, 0, 12'h000, 16'h0);
    expect_out("and_e_cmp", 16'h0F00, 0, 0, 1, 16'h0, 0);
    drive(16'hFFFF, 16'h0000, OP_INC, 1, 1, 1, 0, 12'h000, 16'h0);
    expect_out("inc_wrap", 16'h0000, 1, 0, 1, 16'h0, 0);
    drive(16'h0000, 16'hABCD, OP_PASS_DR, 0, 0, 0, 0, 12'h000, 16'h0);
    expect_out("e_prio_clr", 16'hABCD, 0, 0, 0, 16'h0, 0);
    drive(16'h7FFF, 16'h0000, OP_INC, 1, 1, 0, 0, 12'h000, 16'h0);
    expect_out("inc_ovf", 16'h8000, 0, 1, 0, 16'h0, 0);
    drive(16'h1234, 16'h0000, OP_CLR, 0, 1, 0, 0, 12'h000, 16'h0);
    expect_out("clr_load_beats_cmp", 16'h0000, 0, 0, 0, 16'h0, 0);
    drive(16'h5A5A, 16'h1111, 4'd15, 0, 0, 0, 0, 12'h000, 16'h0);
    expect_out("op15_pass", 16'h5A5A, 0, 0, 1, 16'h0, 0);
    drive(16'h0005, 16'h0007, 4'd9, 0, 0, 0, 0, 12'h000, 16'h0);
`ifdef ALU_SUB_EN
    expect_out("sub_neg", 16'hFFFE, 0, 0, 1, 16'h0, 0);
`else
    expect_out("op9_pass", 16'h0005, 0, 0, 1, 16'h0, 0);
`endif
    drive(16'h8000, 16'h0001, 4'd9, 0, 0, 0, 0, 12'h000, 16'h0);
`ifdef ALU_SUB_EN
    expect_out("sub_ovf", 16'h7FFF, 1, 1, 1, 16'h0, 0);
`else
    expect_out("op9_pass_neg", 16'h8000, 0, 0, 1, 16'h0, 0);
`endif
    drive(16'h4000, 16'h0000, OP_CIL, 0, 0, 0, 0, 12'h000, 16'h0);
    expect_out("cil_e_in", 16'h8001, 0, 0, 1, 16'h0, 0);

    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 0, 1, 12'h0A5, 16'hBEEF);
    expect_out("mem_wr1", 16'h0000, 0, 0, 1, 16'h0, 0);
    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 0, 1, 12'hFFF, 16'h1234);
    expect_out("mem_wr2", 16'h0000, 0, 0, 1, 16'h0, 0);
    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 0, 0, 12'h0A5, 16'h0);
    expect_out("mem_rd_0a5", 16'h0000, 0, 0, 1, 16'hBEEF, 1);
    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 0, 0, 12'hFFF, 16'h0);
    expect_out("mem_rd_fff", 16'h0000, 0, 0, 1, 16'h1234, 1);
    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 0, 1, 12'h0A5, 16'h5555);
    expect_out("mem_same_cycle", 16'h0000, 0, 0, 1, 16'hBEEF, 1);
    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 0, 0, 12'h0A5, 16'h0);
    expect_out("mem_after_edge", 16'h0000, 0, 0, 1, 16'h5555, 1);

    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 0, 0, 12'h0A5, 16'h0);
    #2 RST_N = 1'b0;
    expect_out("async_rst", 16'h0000, 0, 0, 0, 16'h5555, 1);
    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 1, 0, 0, 12'hFFF, 16'h0);
    RST_N = 1'b1;
    expect_out("rst_release", 16'h0000, 0, 0, 0, 16'h1234, 1);
    drive(16'h0000, 16'h0000, OP_PASS_AC, 0, 0, 0, 0, 12'hFFF, 16'h0);
    expect_out("post_rst_cmp", 16'h0000, 0, 0, 1, 16'h1234, 1);
    done = 1'b1;
  end

endmodule
